// File: rtl/mem_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stall_controller_pkg
//  Brief    : Shared definitions for the MEM-stage miss stall controller:
//             controller state encoding, counter widths, address helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stall_controller_pkg;

    localparam int c_STATE_W = 3;
    localparam int c_MISS_W  = 16;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FILL  = 3'd3,
        ST_ERROR = 3'd4
    } ctrlState_t;

    localparam logic [c_MISS_W-1:0] c_MISS_MAX = '1;

    // Clear the byte-offset bits so the refill starts on a block boundary.
    function automatic logic [31:0] blockAlign(input logic [31:0] addr,
                                               input int          blockBytes);
        logic [31:0] w_offsetMask;
        w_offsetMask = 32'(blockBytes) - 32'd1;
        return addr & ~w_offsetMask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : stall_timeout_counter
//  Brief    : Refill watchdog. Counts cycles while enabled; the terminal
//             output marks the TIMEOUT-th enabled cycle since the last clear.
//  Revision : 1.0 - initial release
// ============================================================================
module stall_timeout_counter
    import mem_stall_controller_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    // Values 0..TIMEOUT-1 are needed; a count of TIMEOUT-1 is the last
    // permitted cycle, so the counter never has to represent TIMEOUT itself.
    localparam int                  c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    // Clear on reset or refill start; count up while enabled, holding at the last value.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stall_controller
//  Brief    : Stalls the pipeline on a MEM-stage cache miss, requests a
//             block refill from main memory, strobes the cache fill, and
//             flags a sticky bus error if memory does not answer in time.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stall_controller
    import mem_stall_controller_pkg::*;
#(
    parameter int BLOCK_BYTES = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memAccess,
    input  logic                hit,
    input  logic [31:0]         address,
    input  logic                memAck,
    input  logic                memReady,
    output logic                stall,
    output logic                wbBubble,
    output logic                memReq,
    output logic [31:0]         memAddr,
    output logic                fillWrite,
    output logic                busError,
    output logic [c_MISS_W-1:0] missCount
);

    ctrlState_t          r_state;
    ctrlState_t          w_nextState;
    logic [31:0]         r_memAddr;
    logic [c_MISS_W-1:0] r_missCount;
    logic                r_busError;

    logic w_stall;
    logic w_memReq;
    logic w_fillWrite;
    logic w_missStart;
    logic w_timerClear;
    logic w_timerEnable;
    logic w_timeout;

    stall_timeout_counter #(
        .TIMEOUT    (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_timerClear),
        .i_enable   (w_timerEnable),
        .o_terminal (w_timeout)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Moore/Mealy outputs; the timeout wins over any memory response.
    always_comb begin
        w_nextState   = r_state;
        w_stall       = 1'b0;
        w_memReq      = 1'b0;
        w_fillWrite   = 1'b0;
        w_missStart   = 1'b0;
        w_timerClear  = 1'b0;
        w_timerEnable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (memAccess && !hit) begin
                    w_stall      = 1'b1;
                    w_missStart  = 1'b1;
                    w_timerClear = 1'b1;
                    w_nextState  = ST_REQ;
                end
            end
            ST_REQ: begin
                w_stall       = 1'b1;
                w_memReq      = 1'b1;
                w_timerEnable = 1'b1;
                if (w_timeout) begin
                    w_nextState = ST_ERROR;
                end else if (memAck && memReady) begin
                    w_nextState = ST_FILL;
                end else if (memAck) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall       = 1'b1;
                w_timerEnable = 1'b1;
                if (w_timeout) begin
                    w_nextState = ST_ERROR;
                end else if (memReady) begin
                    w_nextState = ST_FILL;
                end
            end
            ST_FILL: begin
                w_stall     = 1'b1;
                w_fillWrite = 1'b1;
                w_nextState = ST_IDLE;
            end
            ST_ERROR: begin
                w_stall = 1'b1;
            end
            default: begin
                w_stall     = 1'b1;
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Capture the block-aligned refill address when a miss is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_memAddr <= '0;
        end else if (w_missStart) begin
            r_memAddr <= blockAlign(address, BLOCK_BYTES);
        end
    end

    // Saturating miss counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_missCount <= '0;
        end else if (w_missStart && (r_missCount != c_MISS_MAX)) begin
            r_missCount <= r_missCount + c_MISS_W'(1);
        end
    end

    // Sticky bus-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busError <= 1'b0;
        end else if (w_nextState == ST_ERROR) begin
            r_busError <= 1'b1;
        end
    end

    assign stall     = w_stall;
    assign wbBubble  = w_stall;
    assign memReq    = w_memReq;
    assign fillWrite = w_fillWrite;
    assign memAddr   = r_memAddr;
    assign missCount = r_missCount;
    assign busError  = r_busError;

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stall_controller
//  Brief    : Self-checking bench for mem_stall_controller. A driver issues
//             misses with random memory latencies and queues the expected
//             refill; a monitor pops the queue on every fill strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stall_controller;

    localparam int          BB         = 16;
    localparam int          TO         = 8;
    localparam logic [31:0] ALIGN_MASK = ~(32'(BB) - 32'd1);

    logic        clk = 1'b0;
    logic        reset;
    logic        memAccess;
    logic        hit;
    logic [31:0] address;
    logic        memAck;
    logic        memReady;
    logic        stall;
    logic        wbBubble;
    logic        memReq;
    logic [31:0] memAddr;
    logic        fillWrite;
    logic        busError;
    logic [15:0] missCount;

    mem_stall_controller #(
        .BLOCK_BYTES (BB),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memAccess (memAccess),
        .hit       (hit),
        .address   (address),
        .memAck    (memAck),
        .memReady  (memReady),
        .stall     (stall),
        .wbBubble  (wbBubble),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .fillWrite (fillWrite),
        .busError  (busError),
        .missCount (missCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   modelCount = 0;
    bit   monEn      = 1'b0;
    bit   prevFill   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int satInc(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    // Monitor: every fill strobe must match the oldest queued refill.
    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            if (fillWrite) begin
                chk("fillPulseWidth", {31'd0, prevFill}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpectedFill: fill strobe at addr %0h with nothing queued", memAddr);
                end else begin
                    e = sb.pop_front();
                    chk("fillAddr", memAddr, e.addr);
                    chk("fillMissCount", {16'd0, missCount}, {16'd0, e.cnt});
                end
            end
            prevFill = fillWrite;
        end else begin
            prevFill = 1'b0;
        end
    end

    // One non-missing cycle with random noise on the memory handshake.
    task automatic idleCycle();
        memAccess = 1'($urandom_range(0, 1));
        hit       = memAccess ? 1'b1 : 1'($urandom_range(0, 1));
        address   = $urandom;
        memAck    = 1'($urandom_range(0, 1));
        memReady  = 1'($urandom_range(0, 1));
        #1;
        chk("idleStall", {31'd0, stall}, 32'd0);
        chk("idleBubble", {31'd0, wbBubble}, 32'd0);
        chk("idleReq", {31'd0, memReq}, 32'd0);
        @(negedge clk);
    endtask

    // Miss with `a` REQ cycles before ack, memReady on the r-th WAIT cycle (0 = with ack).
    task automatic doMiss(input logic [31:0] addr, input int a, input int r);
        logic [31:0] al;
        exp_t        e;
        al        = addr & ALIGN_MASK;
        memAccess = 1'b1;
        hit       = 1'b0;
        address   = addr;
        memAck    = 1'b0;
        memReady  = 1'b0;
        #1;
        chk("missStallSameCycle", {31'd0, stall}, 32'd1);
        chk("missBubble", {31'd0, wbBubble}, 32'd1);
        modelCount = satInc(modelCount);
        e.addr     = al;
        e.cnt      = modelCount[15:0];
        sb.push_back(e);
        @(negedge clk);
        for (int i = 0; i < a; i++) begin
            chk("reqHeld", {31'd0, memReq}, 32'd1);
            chk("reqStall", {31'd0, stall}, 32'd1);
            address = $urandom;
            @(negedge clk);
        end
        chk("reqAckCycle", {31'd0, memReq}, 32'd1);
        chk("memAddrLatched", memAddr, al);
        memAck   = 1'b1;
        memReady = (r == 0);
        @(negedge clk);
        memAck   = 1'b0;
        memReady = 1'b0;
        for (int j = 1; j <= r; j++) begin
            chk("waitNoReq", {31'd0, memReq}, 32'd0);
            chk("waitStall", {31'd0, stall}, 32'd1);
            chk("waitAddrStable", memAddr, al);
            memAck   = 1'($urandom_range(0, 1));
            memReady = (j == r);
            @(negedge clk);
        end
        memAck   = 1'b0;
        memReady = 1'b0;
        chk("fillCycle", {31'd0, fillWrite}, 32'd1);
        chk("fillStall", {31'd0, stall}, 32'd1);
        hit = 1'b1;
        @(negedge clk);
        #1;
        chk("replayNoStall", {31'd0, stall}, 32'd0);
        chk("replayBubble", {31'd0, wbBubble}, 32'd0);
        chk("replayNoFill", {31'd0, fillWrite}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        memAccess = 1'b0;
        hit       = 1'b0;
        address   = 32'd0;
        memAck    = 1'b0;
        memReady  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstStall", {31'd0, stall}, 32'd0);
        chk("rstReq", {31'd0, memReq}, 32'd0);
        chk("rstFill", {31'd0, fillWrite}, 32'd0);
        chk("rstBusError", {31'd0, busError}, 32'd0);
        chk("rstMemAddr", memAddr, 32'd0);
        chk("rstMissCount", {16'd0, missCount}, 32'd0);
        reset = 1'b0;
        monEn = 1'b1;

        // Hit path and no-access path never stall.
        memAccess = 1'b1;
        hit       = 1'b1;
        address   = 32'h0000_1234;
        repeat (3) begin
            #1;
            chk("hitNoStall", {31'd0, stall}, 32'd0);
            chk("hitNoReq", {31'd0, memReq}, 32'd0);
            @(negedge clk);
        end
        chk("hitMissCount", {16'd0, missCount}, 32'd0);
        memAccess = 1'b0;
        hit       = 1'b0;
        #1;
        chk("noAccessNoStall", {31'd0, stall}, 32'd0);
        @(negedge clk);

        // Directed miss, then the simultaneous ack/ready shortcut.
        doMiss(32'h0000_1234, 1, 3);
        chk("missCountOne", {16'd0, missCount}, 32'd1);
        doMiss($urandom, 0, 0);
        doMiss($urandom, 2, 0);

        // Random traffic.
        repeat (25) begin
            repeat ($urandom_range(0, 3)) idleCycle();
            doMiss($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        chk("randomMissCount", {16'd0, missCount}, modelCount);

        // Reset while waiting for refill data.
        memAccess = 1'b1;
        hit       = 1'b0;
        address   = $urandom;
        @(negedge clk);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        chk("inWaitNoReq", {31'd0, memReq}, 32'd0);
        monEn = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        memAccess = 1'b0;
        sb.delete();
        modelCount = 0;
        monEn      = 1'b1;
        #1;
        chk("rstWaitReq", {31'd0, memReq}, 32'd0);
        chk("rstWaitStall", {31'd0, stall}, 32'd0);
        chk("rstWaitFill", {31'd0, fillWrite}, 32'd0);
        chk("rstWaitMissCount", {16'd0, missCount}, 32'd0);
        chk("rstWaitMemAddr", memAddr, 32'd0);
        @(negedge clk);
        repeat (3) idleCycle();

        // Saturation: preload near the top, then miss past it.
        force dut.r_missCount = 16'hFFFD;
        #1;
        release dut.r_missCount;
        chk("preloadMissCount", {16'd0, missCount}, 32'h0000_FFFD);
        modelCount = 65533;
        @(negedge clk);
        repeat (4) doMiss($urandom, 0, 1);
        chk("satMissCount", {16'd0, missCount}, 32'h0000_FFFF);

        // Timeout: memory never acknowledges.
        memAccess = 1'b1;
        hit       = 1'b0;
        address   = $urandom;
        @(negedge clk);
        for (int i = 0; i < TO; i++) begin
            chk("toReqHeld", {31'd0, memReq}, 32'd1);
            chk("toNoBusError", {31'd0, busError}, 32'd0);
            @(negedge clk);
        end
        chk("toBusError", {31'd0, busError}, 32'd1);
        chk("toNoReq", {31'd0, memReq}, 32'd0);
        chk("toStall", {31'd0, stall}, 32'd1);
        repeat (4) begin
            memAccess = 1'b0;
            memAck    = 1'($urandom_range(0, 1));
            memReady  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("errSticky", {31'd0, busError}, 32'd1);
            chk("errStall", {31'd0, stall}, 32'd1);
            chk("errNoReq", {31'd0, memReq}, 32'd0);
        end
        memAck   = 1'b0;
        memReady = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("errRstBusError", {31'd0, busError}, 32'd0);
        chk("errRstStall", {31'd0, stall}, 32'd0);
        chk("errRstMissCount", {16'd0, missCount}, 32'd0);
        @(negedge clk);

        chk("scoreboardDrained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
